// File: rtl/piarb2_pkg.sv
// Shared definitions for the two-master PerInt arbiter: op codes, FSM states, width helper.
package piarb2_pkg;

  typedef logic [1:0] op_t;

  localparam op_t PINOOP = 2'b00;
  localparam op_t PIWROP = 2'b01;
  localparam op_t PIRDOP = 2'b10;
  localparam op_t PIRWOP = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/piarb2_if.sv
// One PerInt link. The requester drives op/addr/data/sel; the device answers rdata/rdy/mapsz.
interface piarb2_if #(
  parameter int ARCHBITSZ = 16,
  parameter int ADDRBITSZ = 15
);
  logic [1:0]             op;
  logic [ADDRBITSZ-1:0]   addr;
  logic [ARCHBITSZ-1:0]   data;
  logic [ARCHBITSZ/8-1:0] sel;
  logic [ARCHBITSZ-1:0]   rdata;
  logic                   rdy;
  logic [ARCHBITSZ-1:0]   mapsz;

  modport master (output op, addr, data, sel, input  rdata, rdy, mapsz);
  modport slave  (input  op, addr, data, sel, output rdata, rdy, mapsz);
endinterface

// File: rtl/piarb2_rrsel.sv
// Round-robin grant selector with stall lock. PIARB2_BURST_EN keeps the grant for up to
// MAXBURST accepted ops per master before handing over.
module piarb2_rrsel
  import piarb2_pkg::*;
#(
  parameter int MAXBURST = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req,
  input  logic       accept,
  input  logic       s_rdy,
  output logic [1:0] grant
);

  state_t state;
  logic   ptr;
  logic   gv;
  logic   gidx;
  state_t lock_st;

  // A held master keeps the grant; otherwise fall back to pointer arbitration.
  always_comb begin
    gv   = 1'b1;
    gidx = 1'b0;
    if (state == LOCK0 && req[0])      gidx = 1'b0;
    else if (state == LOCK1 && req[1]) gidx = 1'b1;
    else if (req == 2'b11)             gidx = ptr;
    else if (req[1])                   gidx = 1'b1;
    else if (req[0])                   gidx = 1'b0;
    else                               gv   = 1'b0;
    grant   = gv ? (gidx ? 2'b10 : 2'b01) : 2'b00;
    lock_st = gidx ? LOCK1 : LOCK0;
  end

`ifdef PIARB2_BURST_EN
  logic [7:0] cnt;
  logic [7:0] cnt_base;
  logic [8:0] cnt_nxt;

  // The count only carries over while the same master stays locked.
  assign cnt_base = (state == lock_st) ? cnt : 8'd0;
  assign cnt_nxt  = {1'b0, cnt_base} + 9'd1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      ptr   <= 1'b0;
      cnt   <= 8'd0;
    end else if (!gv) begin
      state <= IDLE;
      cnt   <= 8'd0;
      if (state != IDLE) ptr <= (state == LOCK0);
    end else if (accept) begin
      if (int'(cnt_nxt) >= MAXBURST) begin
        ptr   <= ~gidx;
        state <= IDLE;
        cnt   <= 8'd0;
      end else begin
        state <= lock_st;
        cnt   <= cnt_nxt[7:0];
      end
    end else begin
      state <= s_rdy ? IDLE : lock_st;
      cnt   <= cnt_base;
    end
  end
`else
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      ptr   <= 1'b0;
    end else if (!gv) begin
      state <= IDLE;
    end else if (accept) begin
      ptr   <= ~gidx;
      state <= IDLE;
    end else begin
      state <= s_rdy ? IDLE : lock_st;
    end
  end
`endif

endmodule

// File: rtl/piarb2.sv
// Two-master PerInt arbiter: combinational request mux, rdy gating and read-data routing.
// Optional burst grants are enabled with the PIARB2_BURST_EN macro.
module piarb2
  import piarb2_pkg::*;
#(
  parameter int ARCHBITSZ = 16,
  parameter int MAXBURST  = 4
) (
  input  logic    clk_i,
  input  logic    rst_i,
  piarb2_if.slave  m0,
  piarb2_if.slave  m1,
  piarb2_if.master s
);

  localparam int ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ / 8);

  logic [1:0]             req;
  logic [1:0]             grant;
  logic                   accept;
  logic                   rd_vld;
  logic                   rd_owner;
  logic [1:0]             op_mux;
  logic [ADDRBITSZ-1:0]   addr_mux;
  logic [ARCHBITSZ-1:0]   data_mux;
  logic [ARCHBITSZ/8-1:0] sel_mux;

  assign req = {m1.op != PINOOP, m0.op != PINOOP};

  piarb2_rrsel #(.MAXBURST(MAXBURST)) u_rrsel (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .req    (req),
    .accept (accept),
    .s_rdy  (s.rdy),
    .grant  (grant)
  );

  always_comb begin
    op_mux   = PINOOP;
    addr_mux = '0;
    data_mux = '0;
    sel_mux  = '0;
    if (grant[0]) begin
      op_mux   = m0.op;
      addr_mux = m0.addr;
      data_mux = m0.data;
      sel_mux  = m0.sel;
    end else if (grant[1]) begin
      op_mux   = m1.op;
      addr_mux = m1.addr;
      data_mux = m1.data;
      sel_mux  = m1.sel;
    end
  end

  assign s.op   = op_mux;
  assign s.addr = addr_mux;
  assign s.data = data_mux;
  assign s.sel  = sel_mux;

  // A grant only exists for a requesting master, so grant plus ready is an acceptance.
  assign accept = (|grant) & s.rdy;
  assign m0.rdy = grant[0] & s.rdy;
  assign m1.rdy = grant[1] & s.rdy;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_vld   <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_vld   <= accept && (op_mux == PIRDOP || op_mux == PIRWOP);
      rd_owner <= grant[1];
    end
  end

  assign m0.rdata = (rd_vld && !rd_owner) ? s.rdata : '0;
  assign m1.rdata = (rd_vld &&  rd_owner) ? s.rdata : '0;
  assign m0.mapsz = s.mapsz;
  assign m1.mapsz = s.mapsz;

endmodule

// File: tb/tb_piarb2.sv
// Scoreboard bench for piarb2: stimulus queues expected slave requests and read returns,
// a negedge monitor pops and compares them.
module tb_piarb2;
  import piarb2_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  piarb2_if #(.ARCHBITSZ(16), .ADDRBITSZ(15)) m0_if ();
  piarb2_if #(.ARCHBITSZ(16), .ADDRBITSZ(15)) m1_if ();
  piarb2_if #(.ARCHBITSZ(16), .ADDRBITSZ(15)) s_if ();

  piarb2 #(.ARCHBITSZ(16), .MAXBURST(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if)
  );

  typedef struct packed {
    logic [1:0]  op;
    logic [14:0] addr;
    logic [15:0] data;
    logic [1:0]  sel;
    logic        r0;
    logic        r1;
  } req_t;

  req_t        exq[$];
  logic [15:0] rdq0[$];
  logic [15:0] rdq1[$];
  int          n_chk = 0;
  int          n_err = 0;

  // Slave: registered read data one cycle after an accepted read, junk otherwise.
  always @(posedge clk)
    s_if.rdata <= (s_if.op[1] && s_if.rdy) ? (16'hA000 | {1'b0, s_if.addr}) : 16'hDEAD;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // eg: expected grant 0=none, 1=m0, 2=m1
  task automatic cyc(input logic [1:0] o0, input logic [14:0] a0,
                     input logic [1:0] o1, input logic [14:0] a1,
                     input logic srdy, input int eg, input bit keep_rd = 1'b1);
    req_t e;
    m0_if.op = o0; m0_if.addr = a0;
    m1_if.op = o1; m1_if.addr = a1;
    s_if.rdy = srdy;
    if (eg != 0) begin
      e.op   = (eg == 1) ? o0 : o1;
      e.addr = (eg == 1) ? a0 : a1;
      e.data = (eg == 1) ? 16'h1111 : 16'h2222;
      e.sel  = (eg == 1) ? 2'b11 : 2'b10;
      e.r0   = (eg == 1) && srdy;
      e.r1   = (eg == 2) && srdy;
      exq.push_back(e);
      if (srdy && e.op[1] && keep_rd) begin
        if (eg == 1) rdq0.push_back(16'hA000 | {1'b0, a0});
        else         rdq1.push_back(16'hA000 | {1'b0, a1});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(PINOOP, 15'h0, PINOOP, 15'h0, 1'b1, 0);
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor
  initial begin
    req_t e;
    logic [15:0] d;
    forever begin
      @(negedge clk);
      check("mapsz", {s_if.mapsz, m0_if.mapsz, m1_if.mapsz}, {3{16'h0020}});
      if (s_if.op !== PINOOP) begin
        if (exq.size() == 0) begin
          check("unexpected_req", {s_if.op, s_if.addr}, 0);
        end else begin
          e = exq.pop_front();
          check("slave_req", {s_if.op, s_if.addr, s_if.data, s_if.sel, m0_if.rdy, m1_if.rdy}, e);
        end
      end else begin
        check("rdy_idle", {m0_if.rdy, m1_if.rdy}, 2'b00);
      end
      if (m0_if.rdata !== 16'h0) begin
        d = (rdq0.size() != 0) ? rdq0.pop_front() : 16'h0;
        check("m0_rdata", m0_if.rdata, d);
      end
      if (m1_if.rdata !== 16'h0) begin
        d = (rdq1.size() != 0) ? rdq1.pop_front() : 16'h0;
        check("m1_rdata", m1_if.rdata, d);
      end
    end
  end

  int eg2[4];
  int eg5[5];

  initial begin
`ifdef PIARB2_BURST_EN
    eg2 = '{1, 1, 2, 2};
    eg5 = '{1, 1, 2, 2, 1};
`else
    eg2 = '{1, 2, 1, 2};
    eg5 = '{1, 2, 1, 2, 1};
`endif
    m0_if.op = PINOOP; m0_if.addr = '0; m0_if.data = 16'h1111; m0_if.sel = 2'b11;
    m1_if.op = PINOOP; m1_if.addr = '0; m1_if.data = 16'h2222; m1_if.sel = 2'b10;
    s_if.rdy = 1'b0;
    s_if.mapsz = 16'h0020;
    #2;
    check("rst_rdy",   {m0_if.rdy, m1_if.rdy}, 2'b00);
    check("rst_rdata", {m0_if.rdata, m1_if.rdata}, 32'h0);
    check("rst_sop",   s_if.op, PINOOP);
    check("rst_mapsz", {m0_if.mapsz, m1_if.mapsz}, {2{16'h0020}});
    #10 rst = 1'b0;
    @(posedge clk);
    #1;

    // single requester, data returns next cycle
    cyc(PIRDOP, 15'h5, PINOOP, 15'h0, 1'b1, 1);
    idle();

    // contention alternation, data follows owner
    rst_pulse();
    for (int i = 0; i < 4; i++) cyc(PIRDOP, 15'h1, PIRDOP, 15'h2, 1'b1, eg2[i]);
    idle();

    // stall lock on m1, m0 cannot steal
    cyc(PINOOP, 15'h0, PIWROP, 15'h9, 1'b0, 2);
    cyc(PIRDOP, 15'h6, PIWROP, 15'h9, 1'b0, 2);
    cyc(PIRDOP, 15'h6, PIWROP, 15'h9, 1'b0, 2);
    cyc(PIRDOP, 15'h6, PIWROP, 15'h9, 1'b1, 2);
    cyc(PIRDOP, 15'h6, PINOOP, 15'h0, 1'b1, 1);
    idle();

    // async reset one cycle after acceptance drops the pending read
    cyc(PIRDOP, 15'h7, PINOOP, 15'h0, 1'b1, 1, 1'b0);
    m0_if.op = PINOOP;
    rst = 1'b1;
    #1;
    check("rst_drop_rdata", {m0_if.rdata, m1_if.rdata}, 32'h0);
    check("rst_mid_sop", {s_if.op, m0_if.rdy, m1_if.rdy}, 4'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    cyc(PIRDOP, 15'h3, PIRDOP, 15'h4, 1'b1, 1);
    idle();

    // longer contention run (burst pattern when enabled)
    rst_pulse();
    for (int i = 0; i < 5; i++) cyc(PIRDOP, 15'hA, PIRDOP, 15'hB, 1'b1, eg5[i]);
    idle();
    idle();

    check("exq_empty",  exq.size(), 0);
    check("rdq0_empty", rdq0.size(), 0);
    check("rdq1_empty", rdq1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/piarb2.md
# piarb2

Two-master PerInt arbiter that shares one PerInt slave (boot ROM, small RAM, any single-port PerInt device) between two requesters, such as a core fetch port and a debug/loader port. It grants the slave by round-robin, holds the grant while the slave stalls, and routes registered read data back to the master whose read was accepted. It sits between the masters and the slave on the same clock, with no added request latency.

## Interface
- ARCHBITSZ, 16: data width; ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ/8).
- MAXBURST, 4: maximum consecutive accepted ops per grant (used only with PIARB2_BURST_EN); range 1..255.

- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- m0_op_i, m1_op_i  in  2  master op: NOOP=00, WR=01, RD=10, RW=11.
- m0_addr_i, m1_addr_i  in  ADDRBITSZ  word address.
- m0_data_i, m1_data_i  in  ARCHBITSZ  write data.
- m0_sel_i, m1_sel_i  in  ARCHBITSZ/8  byte selects.
- m0_data_o, m1_data_o  out  ARCHBITSZ  read data.
- m0_rdy_o, m1_rdy_o  out  1  op accepted this cycle when high with op != NOOP.
- m0_mapsz_o, m1_mapsz_o  out  ARCHBITSZ  copy of s_mapsz_i.
- s_op_o, s_addr_o, s_data_o, s_sel_o  out  2/ADDRBITSZ/ARCHBITSZ/ARCHBITSZ/8  to slave.
- s_data_i  in  ARCHBITSZ  slave read data, valid the cycle after RD/RW acceptance.
- s_rdy_i  in  1  slave ready.
- s_mapsz_i  in  ARCHBITSZ  slave map size.

## Operation
- Request: mN_op_i != NOOP.
- FSM states: IDLE, LOCK0, LOCK1. Reset state is IDLE. After reset, the priority pointer favours m0.
- In IDLE, the grant goes to the only requester. If both request, the grant goes to the master the pointer favours. If neither requests, there is no grant and s_op_o = NOOP.
- Granted master's op/addr/data/sel drive the s_* outputs combinationally. The ungranted master's fields drive zeros and it sees rdy_o = 0.
- Granted master sees mN_rdy_o = s_rdy_i. Ungranted master sees 0.
- Acceptance means granted op != NOOP and s_rdy_i = 1.
  - On acceptance, the pointer moves to favour the other master.
  - The FSM goes to IDLE.
- Grant with s_rdy_i = 0: the FSM enters LOCKn. The grant stays with master n until acceptance, or until master n drops its op to NOOP, then IDLE. The other master's request cannot steal the grant.
- Read return: on acceptance of RD/RW, register rd_owner = n with valid = 1; otherwise valid = 0.
  - Next cycle, m{rd_owner}_data_o = s_data_i. The other master's data_o = 0.
  - With valid = 0, both data_o = 0.
- WR acceptance does not set valid.
- mN_mapsz_o = s_mapsz_i for both masters, combinational.
- Reset mid-operation:
  - FSM goes to IDLE, pointer to m0, valid to 0. Any pending read data is dropped.
  - Reset does not cancel a slave op already sampled by the slave.

## Timing
- Request to slave: 0 cycles (combinational mux). Read data: 1 cycle after acceptance, the same as direct attachment.
- Reset values:
  - mN_rdy_o = 0 unless the master is granted (combinational).
  - mN_data_o = 0.
  - s_op_o = NOOP when there are no requests.
  - mapsz outputs follow s_mapsz_i.
- Back-to-back alternation: m0 and m1 both holding RD with s_rdy_i = 1 gives grants m0, m1, m0, …, one acceptance per cycle. Read data follows the owner at +1 cycle.
- Simultaneous request plus rd_owner return: the returning data goes to rd_owner regardless of the current grant.

## Configuration
- PIARB2_BURST_EN defined:
  - After acceptance, the FSM enters LOCKn and the grant stays with n while n keeps requesting.
  - An 8-bit burst counter counts acceptances.
  - On the MAXBURST-th acceptance, or when n goes to NOOP, the pointer flips and the FSM returns to IDLE. The counter clears on grant change and on reset.
- PIARB2_BURST_EN undefined: no counter. The pointer flips on every acceptance, giving strict alternation under contention.

## Structure
- piarb2_pkg holds:
  - Op encodings PINOOP/PIWROP/PIRDOP/PIRWOP.
  - FSM state encodings IDLE/LOCK0/LOCK1.
  - clog2 helper for ADDRBITSZ.
- One sub-module, piarb2_rrsel, holds the pointer, FSM and optional burst counter. It has inputs req[1:0], accept, and slave-ready. It outputs grant[1:0] (one-hot or zero).
- Top level: muxing, rdy gating, rd_owner/valid register.

## Test plan
- Reset, m0 RD addr 0x5 only, s_rdy_i = 1 → s_addr_o = 0x5 same cycle; m0_rdy_o = 1; next cycle m0_data_o = s_data_i, m1_data_o = 0.
- Both RD every cycle (m0 addr 0x1, m1 addr 0x2), no burst → s_addr_o sequence 0x1, 0x2, 0x1, 0x2; data returned to the matching master at +1.
- m1 WR while s_rdy_i = 0 for 3 cycles, m0 raises RD on cycle 2 → grant stays m1 (LOCK1). m1 is accepted on cycle 4, then m0 is granted on cycle 5.
- Assert rst_i asynchronously one cycle after m0 RD acceptance → m0_data_o = 0 immediately; the next grant goes to m0 on contention.
- PIARB2_BURST_EN, MAXBURST = 2, both request continuously → grant pattern m0, m0, m1, m1, m0.
- s_mapsz_i = 0x20 → both mN_mapsz_o = 0x20 in every state, including during reset.
